// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder: symbolic requests in, addressed 32-bit words out.
// The li pseudo-op expands to lui followed by ori through a two-state FSM.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpAddu  = 4'd1;
    localparam logic [3:0] OpSubu  = 4'd2;
    localparam logic [3:0] OpJr    = 4'd3;
    localparam logic [3:0] OpOri   = 4'd4;
    localparam logic [3:0] OpSw    = 4'd5;
    localparam logic [3:0] OpLw    = 4'd6;
    localparam logic [3:0] OpLui   = 4'd7;
    localparam logic [3:0] OpBeq   = 4'd8;
    localparam logic [3:0] OpJal   = 4'd9;
    localparam logic [3:0] OpAddiu = 4'd10;
    localparam logic [3:0] OpJ     = 4'd11;
    localparam logic [3:0] OpLi    = 4'd12;

    typedef enum logic [0:0] {StIdle, StLi2} state_e;

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [31:0] na_q, na_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [4:0]  li_rt_q, li_rt_d;
    logic [15:0] li_lo_q, li_lo_d;

    logic               accept;
    logic [31:0]        enc_word;
    logic               enc_err;
    logic [1:0]         enc_code;
    logic [31:0]        pc4;
    logic [31:0]        br_diff;
    logic signed [31:0] br_off;
    logic               br_ok;

    assign in_ready = (!out_valid_q || out_ready) && (state_q != StLi2);
    assign accept   = in_valid && in_ready;

    // Combinational encoding of the request against the address it would occupy.
    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        enc_code = 2'd0;
        pc4      = na_q + 32'd4;
        br_diff  = imm - pc4;
        br_off   = $signed(br_diff) >>> 2;
        br_ok    = (br_off[31:15] == 17'h00000) || (br_off[31:15] == 17'h1ffff);
        case (op)
            OpNop:   enc_word = 32'h0;
            OpAddu:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
            OpSubu:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
            OpJr:    enc_word = {6'b000000, rs, 5'd0, 5'd0, 5'd0, 6'b001000};
            OpOri:   enc_word = {6'b001101, rs, rt, imm[15:0]};
            OpSw:    enc_word = {6'b101011, rs, rt, imm[15:0]};
            OpLw:    enc_word = {6'b100011, rs, rt, imm[15:0]};
            OpAddiu: enc_word = {6'b001001, rs, rt, imm[15:0]};
            OpLui:   enc_word = {6'b001111, 5'd0, rt, imm[15:0]};
            OpLi:    enc_word = {6'b001111, 5'd0, rt, imm[31:16]};
            OpBeq: begin
                if (imm[1:0] != 2'b00) begin
                    enc_err  = 1'b1;
                    enc_code = 2'd2;
                end else if (!br_ok) begin
                    enc_err  = 1'b1;
                    enc_code = 2'd3;
                end
                enc_word = {6'b000100, rs, rt, br_off[15:0]};
            end
            OpJ, OpJal: begin
                if (imm[1:0] != 2'b00) begin
                    enc_err  = 1'b1;
                    enc_code = 2'd2;
                end else if (imm[31:28] != pc4[31:28]) begin
                    enc_err  = 1'b1;
                    enc_code = 2'd3;
                end
                enc_word = {(op == OpJal) ? 6'b000011 : 6'b000010, imm[27:2]};
            end
            default: begin
                enc_err  = 1'b1;
                enc_code = 2'd1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        na_d        = na_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        li_rt_d     = li_rt_q;
        li_lo_d     = li_lo_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == StLi2) begin
            // The lui word is always pending here; ori follows as soon as it leaves.
            if (out_ready) begin
                out_valid_d = 1'b1;
                out_instr_d = {6'b001101, li_rt_q, li_rt_q, li_lo_q};
                out_addr_d  = na_q;
                na_d        = na_q + 32'd4;
                state_d     = StIdle;
            end
        end else if (accept) begin
            if (enc_err) begin
                err_d      = 1'b1;
                err_code_d = enc_code;
            end else begin
                out_valid_d = 1'b1;
                out_instr_d = enc_word;
                out_addr_d  = na_q;
                na_d        = na_q + 32'd4;
                if (op == OpLi) begin
                    state_d = StLi2;
                    li_rt_d = rt;
                    li_lo_d = imm[15:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_addr_q  <= BASE_ADDR;
            na_q        <= BASE_ADDR;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            li_rt_q     <= 5'd0;
            li_lo_q     <= 16'h0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            na_q        <= na_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            li_rt_q     <= li_rt_d;
            li_lo_q     <= li_lo_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder: stimulus pushes expected words and error
// pulses into queues, an independent negedge monitor pops and compares them.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [4:0]  rs = 5'd0;
    logic [4:0]  rt = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] imm = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_code  (err_code)
    );

    typedef struct { bit [31:0] w; bit [31:0] a; } word_t;
    typedef struct { int c; int code; } err_t;

    word_t     exp_q[$];
    err_t      err_q[$];
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;
    bit [31:0] m_na = BASE;
    bit        li_wait = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference encoder computed from field positions with plain arithmetic.
    function automatic void encode(input int o, input int s, input int t, input int d,
                                   input bit [31:0] im, input bit [31:0] pc,
                                   output int code, output bit [31:0] w);
        bit [31:0] bs = 32'(s) * 32'h0020_0000;
        bit [31:0] bt = 32'(t) * 32'h0001_0000;
        bit [31:0] bd = 32'(d) * 32'h0000_0800;
        bit [31:0] lo = im % 32'h0001_0000;
        bit [31:0] k26 = 32'h0400_0000;
        int diff;
        int off;
        code = 0;
        w = 32'h0;
        case (o)
            0:  w = 32'h0;
            1:  w = bs + bt + bd + 32'd33;
            2:  w = bs + bt + bd + 32'd35;
            3:  w = bs + 32'd8;
            4:  w = 32'd13 * k26 + bs + bt + lo;
            5:  w = 32'd43 * k26 + bs + bt + lo;
            6:  w = 32'd35 * k26 + bs + bt + lo;
            7:  w = 32'd15 * k26 + bt + lo;
            10: w = 32'd9 * k26 + bs + bt + lo;
            8: begin
                if (im % 4 != 0) code = 2;
                else begin
                    diff = int'(im - (pc + 32'd4));
                    off = diff / 4;
                    if (off < -32768 || off > 32767) code = 3;
                    else w = 32'd4 * k26 + bs + bt + (32'(off) & 32'h0000_FFFF);
                end
            end
            9, 11: begin
                if (im % 4 != 0) code = 2;
                else if (im / 32'h1000_0000 != (pc + 32'd4) / 32'h1000_0000) code = 3;
                else w = ((o == 9) ? 32'd3 : 32'd2) * k26 + (im % 32'h1000_0000) / 4;
            end
            default: code = 1;
        endcase
    endfunction

    task automatic accept_model(input int o, input int s, input int t, input int d,
                                input bit [31:0] im);
        int        code;
        bit [31:0] w;
        if (o == 12) begin
            exp_q.push_back('{32'd15 * 32'h0400_0000 + 32'(t) * 32'h0001_0000
                              + im / 32'h0001_0000, m_na});
            exp_q.push_back('{32'd13 * 32'h0400_0000 + 32'(t) * 32'h0020_0000
                              + 32'(t) * 32'h0001_0000 + im % 32'h0001_0000, m_na + 32'd4});
            m_na = m_na + 32'd8;
            li_wait = 1'b1;
        end else begin
            encode(o, s, t, d, im, m_na, code, w);
            if (code != 0) err_q.push_back('{cyc + 1, code});
            else begin
                exp_q.push_back('{w, m_na});
                m_na = m_na + 32'd4;
            end
        end
    endtask

    // Called at a negedge: while the second li word is owed no request may be taken.
    task automatic check_ready();
        if (li_wait) begin
            chk("in_ready_li2", {31'd0, in_ready}, 32'd0);
            if (out_ready) li_wait = 1'b0;
        end else if (out_ready) begin
            chk("in_ready_free", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic send(input int o, input int s, input int t, input int d,
                        input bit [31:0] im, input int pct);
        op = 4'(o);
        rs = 5'(s);
        rt = 5'(t);
        rd = 5'(d);
        imm = im;
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            out_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            check_ready();
            if (in_ready) begin
                accept_model(o, s, t, d, im);
                @(posedge clk);
                #2;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #2;
        end
        total++;
        bad++;
        $display("FAIL send_timeout: got no accept for op %0d want accept within 64 cycles", o);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input int pct, input bit busy);
        in_valid = 1'b0;
        repeat (n) begin
            out_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            check_ready();
            if (busy && !out_ready) chk("stall_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        exp_q.delete();
        err_q.delete();
        m_na = BASE;
        li_wait = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: every valid word must match the queue front; it is retired on handshake.
    word_t mon_e;
    err_t  mon_err;
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h @%h want none", out_instr, out_addr);
                end else begin
                    mon_e = exp_q[0];
                    chk("out_instr", out_instr, mon_e.w);
                    chk("out_addr", out_addr, mon_e.a);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (err_q.size() > 0 && err_q[0].c == cyc) begin
                mon_err = err_q.pop_front();
                chk("err_pulse", {31'd0, err}, 32'd1);
                chk("err_code", {30'd0, err_code}, 32'(mon_err.code));
            end else begin
                chk("no_err", {31'd0, err}, 32'd0);
            end
        end
    end

    function automatic bit [31:0] gen_imm(input int o);
        bit [31:0] v = $urandom;
        int        off;
        int        k;
        if (o == 8) begin
            k = $urandom_range(0, 5);
            case (k)
                0: off = -32768;
                1: off = 32767;
                2: off = -32769;
                3: off = 32768;
                default: off = $urandom_range(0, 200) - 100;
            endcase
            if (k != 5) v = m_na + 32'd4 + 32'(off) * 32'd4;
            if ($urandom_range(0, 7) == 0) v = v | 32'($urandom_range(1, 3));
        end else if (o == 9 || o == 11) begin
            v = v % 32'h1000_0000;
            v = v - v % 4;
            if ($urandom_range(0, 3) == 0) v = v + 32'($urandom_range(0, 15)) * 32'h1000_0000;
            else v = v + ((m_na + 32'd4) / 32'h1000_0000) * 32'h1000_0000;
            if ($urandom_range(0, 7) == 0) v = v | 32'($urandom_range(1, 3));
        end
        return v;
    endfunction

    initial begin
        int o;
        int pct;
        #2;
        do_reset();

        send(1, 1, 2, 3, 32'h0, 100);
        idle(2, 100, 1'b0);
        do_reset();
        send(12, 0, 8, 0, 32'h1234_5678, 100);
        idle(3, 100, 1'b0);
        send(8, 1, 2, 0, 32'h0000_3000, 100);
        send(8, 1, 2, 0, 32'h0000_3002, 100);
        send(9, 0, 0, 0, 32'h0000_3010, 100);
        send(11, 0, 0, 0, 32'h1000_0000, 100);
        send(13, 1, 1, 1, 32'h0, 100);
        send(12, 0, 5, 0, 32'hABCD_0000, 100);
        send(12, 0, 6, 0, 32'h0000_0042, 100);
        send(4, 3, 4, 0, 32'hFFFF_ABCD, 100);
        idle(3, 0, 1'b1);
        idle(3, 100, 1'b0);

        send(12, 0, 9, 0, 32'hDEAD_BEEF, 100);
        idle(1, 0, 1'b1);
        do_reset();
        send(12, 0, 10, 0, 32'h0BAD_F00D, 100);
        idle(3, 100, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            o = $urandom_range(0, 15);
            pct = $urandom_range(30, 100);
            send(o, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 gen_imm(o), pct);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), pct, 1'b0);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        idle(8, 100, 1'b0);
        chk("drain_words", 32'(exp_q.size()), 32'd0);
        chk("drain_errs", 32'(err_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
